alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arbiter_if.sv | 62 ++++++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/alu_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUctr codes and FSM state type shared by the ALU arbiter
package alu_pkg;

    localparam logic [2:0] ADDU = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] OR   = 3'b010;
    localparam logic [2:0] SUBU = 3'b100;
    localparam logic [2:0] SUB  = 3'b101;
    localparam logic [2:0] SLTU = 3'b110;
    localparam logic [2:0] SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU-side signals of alu_arbiter
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_ctr;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_ctr;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_result;
    logic         rsp0_zero;
    logic         rsp0_overflow;

    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_result;
    logic         rsp1_zero;
    logic         rsp1_overflow;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_ctr;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         alu_overflow;

    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctr,
        input  req1_valid, req1_a, req1_b, req1_ctr,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_overflow,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_overflow,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_ctr,
        input  alu_result, alu_zero, alu_overflow,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctr,
        output req1_valid, req1_a, req1_b, req1_ctr,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_overflow,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_overflow,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_ctr,
        output alu_result, alu_zero, alu_overflow,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        if (valid == 2'b00)
            grant = 2'b00;
        else
            grant = grant_id ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters,
// one operation in flight, round-robin on ties, response held until consumed
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t       state;
    logic         grant_id;
    logic         last_grant;
    logic [1:0]   grant;
    logic         grant_now;
    logic         accept_ok;
    logic         rsp_take;

    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [2:0]   alu_ctr_q;

    logic [1:0]   rsp_valid_q;
    logic [N-1:0] rsp0_result_q;
    logic [N-1:0] rsp1_result_q;
    logic [1:0]   rsp_zero_q;
    logic [1:0]   rsp_overflow_q;

    rr_arbiter2 u_rr (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_now)
    );

    // Ready is withheld during reset so a requester never sees a handshake that reset discards.
    assign accept_ok      = (state == IDLE) && !rst;
    assign bus.req0_ready = accept_ok && grant[0];
    assign bus.req1_ready = accept_ok && grant[1];

    assign rsp_take = grant_id ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant_id       <= 1'b0;
            last_grant     <= 1'b1;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctr_q      <= 3'b000;
            rsp_valid_q    <= 2'b00;
            rsp0_result_q  <= '0;
            rsp1_result_q  <= '0;
            rsp_zero_q     <= 2'b00;
            rsp_overflow_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        alu_a_q    <= grant_now ? bus.req1_a   : bus.req0_a;
                        alu_b_q    <= grant_now ? bus.req1_b   : bus.req0_b;
                        alu_ctr_q  <= grant_now ? bus.req1_ctr : bus.req0_ctr;
                        grant_id   <= grant_now;
                        last_grant <= grant_now;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (grant_id) begin
                        rsp1_result_q     <= bus.alu_result;
                        rsp_zero_q[1]     <= bus.alu_zero;
                        rsp_overflow_q[1] <= bus.alu_overflow;
                        rsp_valid_q       <= 2'b10;
                    end else begin
                        rsp0_result_q     <= bus.alu_result;
                        rsp_zero_q[0]     <= bus.alu_zero;
                        rsp_overflow_q[0] <= bus.alu_overflow;
                        rsp_valid_q       <= 2'b01;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.alu_ctr = alu_ctr_q;

    assign bus.rsp0_valid    = rsp_valid_q[0];
    assign bus.rsp0_result   = rsp0_result_q;
    assign bus.rsp0_zero     = rsp_zero_q[0];
    assign bus.rsp0_overflow = rsp_overflow_q[0];

    assign bus.rsp1_valid    = rsp_valid_q[1];
    assign bus.rsp1_result   = rsp1_result_q;
    assign bus.rsp1_zero     = rsp_zero_q[1];
    assign bus.rsp1_overflow = rsp_overflow_q[1];

    assign bus.busy = (state != IDLE);

endmodule
